// File: rtl/jtframe_ps2_rx_if.sv
// PS/2 receiver bundle: raw pins in, decoded byte and strobes out.
// master = pin driver / byte consumer, slave = the receiver itself.
interface jtframe_ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       error;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  data,
    input  valid,
    input  error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output data,
    output valid,
    output error
  );
endinterface

// File: rtl/jtframe_ps2_rx.sv
// PS/2 device-to-host receiver: sync + glitch-filter the pins, deframe 11-bit frames.
// Latency FILTER+4 clk from stop-bit clock fall to valid/error strobe; no backpressure.
module jtframe_ps2_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 60000
) (
  input  logic             clk,
  input  logic             rst,
  jtframe_ps2_rx_if.slave  bus
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic { IDLE, RECV } state_t;

  logic [1:0]        clk_sync;
  logic [1:0]        dat_sync;
  logic [FILTER-1:0] filt;
  logic [FILTER-1:0] dly;
  logic              fclk;
  logic              fall;
  logic              bit_s;

  state_t            st;
  logic [3:0]        cnt;
  logic [7:0]        shreg;
  logic              par;
  logic [IW-1:0]     idle;
  logic [7:0]        data_r;
  logic              valid_r;
  logic              error_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_data};
    end
  end

  // Data runs through a delay line as deep as the clock filter so the
  // sampled bit lines up with the filtered falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt  <= '1;
      dly   <= '1;
      fclk  <= 1'b1;
      fall  <= 1'b0;
      bit_s <= 1'b1;
    end else begin
      filt  <= {filt[FILTER-2:0], clk_sync[1]};
      dly   <= {dly[FILTER-2:0], dat_sync[1]};
      if (filt == '0)
        fclk <= 1'b0;
      else if (filt == '1)
        fclk <= 1'b1;
      fall  <= fclk && (filt == '0);
      bit_s <= dly[FILTER-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= 4'd0;
      shreg   <= 8'd0;
      par     <= 1'b0;
      idle    <= '0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      error_r <= 1'b0;

      if (fall)
        idle <= '0;
      else if (st == RECV && idle != IW'(TIMEOUT))
        idle <= idle + 1'b1;

      case (st)
        IDLE: begin
          if (fall && !bit_s) begin
            st  <= RECV;
            cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            if (cnt <= 4'd8) begin
              shreg <= {bit_s, shreg[7:1]};
              cnt   <= cnt + 4'd1;
            end else if (cnt == 4'd9) begin
              par <= bit_s;
              cnt <= 4'd10;
            end else begin
              st  <= IDLE;
              cnt <= 4'd0;
              if ((^{shreg, par}) && bit_s) begin
                data_r  <= shreg;
                valid_r <= 1'b1;
              end else begin
                error_r <= 1'b1;
              end
            end
          end else if (idle == IW'(TIMEOUT - 1)) begin
            // abort lands exactly TIMEOUT cycles after the last sample
            st      <= IDLE;
            cnt     <= 4'd0;
            idle    <= '0;
            error_r <= 1'b1;
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.data  = data_r;
  assign bus.valid = valid_r;
  assign bus.error = error_r;

endmodule

// File: doc/jtframe_ps2_rx.md
# jtframe_ps2_rx

PS/2 device-to-host serial receiver feeding the keyboard scan-code decoder. It synchronises and de-glitches the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). It presents each received byte as a one-cycle `valid` strobe, or a one-cycle `error` strobe for malformed or stalled frames. It is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- `FILTER`, 8: length of the clock glitch filter in `clk` cycles (≥2).
- `TIMEOUT`, 60000: idle `clk` cycles allowed between bits inside a frame before abort (≈1.25 ms at 48 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `data`  out  8  last good byte; valid while `valid`=1 and held until the next good frame.
- `valid`  out  1  one-cycle strobe: `data` holds a new good byte.
- `error`  out  1  one-cycle strobe: frame rejected (framing, parity or timeout).

## Operation
- Synchroniser: two flops per pin. Reset values are 1 (idle bus).
- Clock filter:
  - `FILTER`-bit shift register of the synchronised clock.
  - Filtered clock `fclk` goes 0 when all bits are 0 and 1 when all bits are 1; otherwise it holds.
  - Reset value of `fclk` and of the shift register is all ones.
- Sample event: `fclk` 1→0 transition, registered. Data is taken from the synchronised `ps2_data` delayed to match the filter (a `FILTER`-deep delay line), so the sample aligns with the clock edge.
- Frame FSM, with a 4-bit bit counter `cnt` from 0 to 10:
  - IDLE (`cnt`=0): on a sample event with data=0, go to RECV and set `cnt`=1. A sample with data=1 is ignored, with no error.
  - RECV: each sample event shifts the bit into `shreg[7]`, right-shifting (LSB first), for `cnt`=1..8. At `cnt`=9 it captures parity. At `cnt`=10 it checks the stop bit, then returns to IDLE and sets `cnt`=0.
  - Check at stop: parity OK means ^{data, parity}=1 (odd), and stop must be 1. Pass: `data`←shreg and `valid`=1. Fail: `error`=1 and `data` is unchanged.
- Timeout: the idle counter clears on every sample event and counts while in RECV, saturating. On reaching `TIMEOUT`: `error`=1, FSM→IDLE, `cnt`=0, partial byte discarded.
- `valid` and `error` are never both 1. Neither is asserted in IDLE except by the stop/timeout rules above.
- Reset values: `data`=0, `valid`=0, `error`=0, FSM IDLE, `cnt`=0, idle counter 0.
- Reset mid-frame discards the partial frame. The remaining bits of that frame are seen as IDLE samples: data=1 samples are ignored, and a data=0 sample starts a spurious frame that will later fail or time out. This is acceptable and must be tested.

## Timing
- Latency: `valid`/`error` rises exactly `FILTER`+4 `clk` edges after the first `clk` edge on which raw `ps2_clk`=0 is stable for the stop bit. Breakdown: 2 sync + `FILTER` filter + 1 edge register + 1 output register.
- Strobes last exactly 1 cycle. `data` updates on the same edge `valid` rises.
- Clock pulses (low or high) shorter than `FILTER` cycles are rejected.
- Minimum supported PS/2 half-period: `FILTER`+2 `clk` cycles. PS/2 devices run at 10–16.7 kHz, far above this at 48 MHz.
- Back-to-back frames need no gap beyond one PS/2 clock period. IDLE accepts the next start bit on the first sample event after stop.
- Timeout is measured between consecutive sample events. Abort occurs exactly `TIMEOUT` cycles after the last one.

## Test plan
- Good frame: send 0x1C at 12 kHz (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> one `valid` pulse, `data`=8'h1C, `error` stays 0; latency `FILTER`+4 from the stop-bit falling edge.
- Sequence E0, F0, 75 back-to-back -> three `valid` pulses with `data` 8'hE0, 8'hF0, 8'h75 in order, no `error`.
- Parity error: 0x29 with parity bit flipped -> one `error` pulse, no `valid`, `data` keeps its previous value.
- Stop error: good 0x16 with stop=0 -> `error` pulse. A following good 0x16 -> `valid`, `data`=8'h16.
- Glitch: 3-cycle low pulses on `ps2_clk` (`FILTER`=8) injected mid-frame, while sending 0x5A -> ignored; `valid` with `data`=8'h5A.
- Timeout and reset: send 4 bits then stall `TIMEOUT`+10 cycles -> `error` exactly `TIMEOUT` cycles after the 4th sample; next good 0x1E -> `valid`. Then assert `rst` for 1 cycle after the 5th bit of a frame -> all outputs 0, no `valid` for that frame; next full good frame 0x26 -> `valid`, `data`=8'h26.
